// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator result tally: FSM states and one-hot flag codes.
package cmp_pkg;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_REPORT = 1'b1
  } state_t;

  localparam logic [2:0] FLG_GT = 3'b100;
  localparam logic [2:0] FLG_EQ = 3'b010;
  localparam logic [2:0] FLG_LT = 3'b001;

  typedef enum logic [1:0] {
    CLS_GT  = 2'd0,
    CLS_EQ  = 2'd1,
    CLS_LT  = 2'd2,
    CLS_ERR = 2'd3
  } flag_cls_t;

  // Any pattern that is not exactly one of the three legal one-hot codes is an error.
  function automatic flag_cls_t classify(input logic [2:0] flags);
    flag_cls_t cls;
    case (flags)
      FLG_GT:  cls = CLS_GT;
      FLG_EQ:  cls = CLS_EQ;
      FLG_LT:  cls = CLS_LT;
      default: cls = CLS_ERR;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/cmp_result_tally.sv
// Tallies comparator gt/eq/lt outcomes (plus illegal flag patterns) over a window of
// WIN_LEN accepted samples and offers the totals on a valid/ready report port.
module cmp_result_tally
  import cmp_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             gt,
  input  logic             eg,
  input  logic             ut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int SMP_W = $clog2(WIN_LEN + 1);

  state_t           state_q;
  state_t           state_d;
  logic [SMP_W-1:0] smp_cnt_q;
  logic [SMP_W-1:0] smp_cnt_d;

  logic      accept;
  logic      report_hs;
  logic      cnt_clr;
  flag_cls_t cls;
  logic      inc_gt;
  logic      inc_eq;
  logic      inc_lt;
  logic      inc_err;

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_REPORT);

  // clear wins over a coincident sample, so the sample is never counted.
  assign accept    = in_valid & in_ready & ~clear;
  assign report_hs = out_valid & out_ready;
  assign cnt_clr   = rst | clear | report_hs;

  assign cls     = classify({gt, eg, ut});
  assign inc_gt  = accept & (cls == CLS_GT);
  assign inc_eq  = accept & (cls == CLS_EQ);
  assign inc_lt  = accept & (cls == CLS_LT);
  assign inc_err = accept & (cls == CLS_ERR);

  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    if (clear) begin
      state_d   = ST_ACCUM;
      smp_cnt_d = '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            smp_cnt_d = smp_cnt_q + SMP_W'(1);
            if (smp_cnt_q == SMP_W'(WIN_LEN - 1)) begin
              state_d = ST_REPORT;
            end
          end
        end
        ST_REPORT: begin
          if (out_ready) begin
            state_d   = ST_ACCUM;
            smp_cnt_d = '0;
          end
        end
        default: begin
          state_d   = ST_ACCUM;
          smp_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      smp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (inc_gt),
    .q   (gt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (inc_eq),
    .q   (eq_cnt)
  );

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (inc_lt),
    .q   (lt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (inc_err),
    .q   (err_cnt)
  );

endmodule

// File: tb/tb_cmp_result_tally.sv
// Directed bench for cmp_result_tally: an 8-bit-counter instance and a 3-bit-counter
// instance share all inputs; flags come from a behavioural 4-bit magnitude comparator.
module tb_cmp_result_tally;

  logic clk = 1'b0;
  logic rst, clear, in_valid, out_ready, gt, eg, ut;

  logic       in_ready, out_valid;
  logic [7:0] gt_cnt, eq_cnt, lt_cnt, err_cnt;
  logic       in_ready3, out_valid3;
  logic [2:0] gt_cnt3, eq_cnt3, lt_cnt3, err_cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_result_tally #(.CNT_W(8), .WIN_LEN(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .gt(gt), .eg(eg), .ut(ut), .out_valid(out_valid), .out_ready(out_ready),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .err_cnt(err_cnt)
  );

  cmp_result_tally #(.CNT_W(3), .WIN_LEN(16)) dut3 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready3),
    .gt(gt), .eg(eg), .ut(ut), .out_valid(out_valid3), .out_ready(out_ready),
    .gt_cnt(gt_cnt3), .eq_cnt(eq_cnt3), .lt_cnt(lt_cnt3), .err_cnt(err_cnt3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_cmp(input logic [3:0] a, input logic [3:0] b);
    gt = (a > b);
    eg = (a == b);
    ut = (a < b);
  endtask

  task automatic drive_flags(input logic [2:0] f);
    {gt, eg, ut} = f;
  endtask

  task automatic chk_counts(input string tag, input int g, input int e, input int l, input int r);
    chk({tag, " gt"},  32'(gt_cnt),  32'(g));
    chk({tag, " eq"},  32'(eq_cnt),  32'(e));
    chk({tag, " lt"},  32'(lt_cnt),  32'(l));
    chk({tag, " err"}, 32'(err_cnt), 32'(r));
  endtask

  task automatic handshake(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " hs out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " hs in_ready"},  32'(in_ready),  32'd1);
    chk_counts({tag, " hs"}, 0, 0, 0, 0);
  endtask

  initial begin
    logic [2:0] pat [16];
    int k;

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    gt = 1'b0; eg = 1'b0; ut = 1'b0;

    // Reset held for two cycles.
    tick();
    tick();
    rst = 1'b0;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk_counts("rst", 0, 0, 0, 0);

    // Sweep a,b over 0..3: 6 greater, 4 equal, 6 less.
    k = 0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        drive_cmp(4'(a), 4'(b));
        in_valid = 1'b1;
        tick();
        k++;
        if (k == 15) chk("sweep out_valid before last", 32'(out_valid), 32'd0);
      end
    end
    in_valid = 1'b0;
    chk("sweep out_valid", 32'(out_valid), 32'd1);
    chk("sweep in_ready",  32'(in_ready),  32'd0);
    chk_counts("sweep", 6, 4, 6, 0);

    // Report held with out_ready low while samples keep arriving.
    drive_flags(3'b100);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("hold out_valid", 32'(out_valid), 32'd1);
    chk("hold in_ready",  32'(in_ready),  32'd0);
    chk_counts("hold", 6, 4, 6, 0);
    handshake("sweep");

    // Illegal patterns: 110 x3, 000 x2, then 001 x11.
    for (int i = 0; i < 16; i++) pat[i] = (i < 3) ? 3'b110 : (i < 5) ? 3'b000 : 3'b001;
    for (int i = 0; i < 16; i++) begin
      drive_flags(pat[i]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("illegal out_valid", 32'(out_valid), 32'd1);
    chk_counts("illegal", 0, 0, 11, 5);
    handshake("illegal");

    // a=9, b=2 sixteen times: 3-bit counter saturates at 7.
    drive_cmp(4'd9, 4'd2);
    in_valid = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("sat out_valid3 before last", 32'(out_valid3), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("sat out_valid3", 32'(out_valid3), 32'd1);
    chk("sat gt_cnt3",    32'(gt_cnt3),    32'd7);
    chk("sat eq_cnt3",    32'(eq_cnt3),    32'd0);
    chk("sat gt_cnt8",    32'(gt_cnt),     32'd16);
    handshake("sat");

    // Five accepts, then clear with a coincident greater sample that must be dropped.
    drive_cmp(4'd5, 4'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre-clear gt", 32'(gt_cnt), 32'd5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_counts("clear", 0, 0, 0, 0);
    chk("clear in_ready", 32'(in_ready), 32'd1);

    drive_cmp(4'd7, 4'd7);
    for (int i = 0; i < 15; i++) tick();
    chk("eq window out_valid before last", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("eq window out_valid", 32'(out_valid), 32'd1);
    chk_counts("eq window", 0, 16, 0, 0);

    // Reset while the report is pending.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid-report rst out_valid", 32'(out_valid), 32'd0);
    chk("mid-report rst in_ready",  32'(in_ready),  32'd1);
    chk_counts("mid-report rst", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
